trdb_branch_map: RTL
====================

# trdb_branch_map

Accumulates the taken/not-taken outcome of each retired conditional branch into a LSB-first branch map and branch count. The trace encoder's packet emitter reads it when building format 0/1/2 payloads. Sits between the instruction-retire filter (upstream, one branch per cycle max) and the packet emitter (downstream). When the map fills, it requests a packet and holds until the emitter flushes it.

## Interface
Parameters:
- MAP_LEN, default trdb_pkg::BRANCH_MAP_LEN (30): number of map bits.
- CNT_W, default $clog2(MAP_LEN+1) (5): width of the branch count.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  a conditional branch retired this cycle.
- taken_i  in  1  outcome of that branch: 1 = taken. Ignored when valid_i=0.
- flush_i  in  1  the emitter has captured map_o/count_o this cycle; clear the map.
- map_o  out  MAP_LEN  branch map; bit i = branch i in retire order; 1 = not taken, 0 = taken.
- count_o  out  CNT_W  number of valid map bits (0..MAP_LEN).
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == MAP_LEN; a packet request to the emitter.
- overflow_o  out  1  sticky; set when a branch is dropped; cleared only by reset.

## Operation
- State machine trdb_bm_state_e:
  - S_EMPTY: count 0.
  - S_ACCUM: 0 < count < MAP_LEN.
  - S_FULL: count == MAP_LEN.
- Write rule: on valid_i, bit[count] <= ~taken_i and count <= count+1. Bits at index ≥ count are always 0.
- Flush rule: on flush_i, map <= 0 and count <= 0 before any write in the same cycle.
- Simultaneous flush_i and valid_i (any state): the result is map = {0…, ~taken_i} and count = 1, giving S_ACCUM. The branch is never lost.
- S_EMPTY:
  - valid_i → S_ACCUM.
  - flush_i alone → stays S_EMPTY, no effect.
- S_ACCUM:
  - valid_i with count==MAP_LEN-1 → S_FULL.
  - flush_i alone → S_EMPTY.
- S_FULL:
  - flush_i alone → S_EMPTY.
  - valid_i without flush_i → branch dropped, map and count unchanged, overflow_o <= 1, stays S_FULL.
- Count arithmetic is unsigned CNT_W bits. count never exceeds MAP_LEN and never wraps.
- flush_i is legal in any state. The emitter may flush a partial map, e.g. on a trap or sync packet.

## Timing
- Reset values:
  - map_o = 0, count_o = 0.
  - empty_o = 1, full_o = 0, overflow_o = 0.
  - state = S_EMPTY.
- All outputs are registered. An input in cycle N is visible on the outputs in cycle N+1, so latency is 1 cycle.
- full_o/empty_o derive from registered state with no combinational path from inputs.
- Handshake: full_o stays high until the cycle after flush_i is sampled. The emitter must assert flush_i in the same cycle it samples map_o/count_o. Upstream is not back-pressured, and drops are flagged via overflow_o.
- Reset asserted mid-accumulation clears everything immediately (asynchronous). The first edge after reset deassertion accepts valid_i normally.

## Structure
- trdb_pkg additions:
  - typedef enum logic[1:0] trdb_bm_state_e {S_EMPTY, S_ACCUM, S_FULL}.
  - BRANCH_MAP_CNT_W = $clog2(BRANCH_MAP_LEN+1). The existing BRANCH_COUNT_LEN is too narrow for a 30-bit map.
- Single module, no sub-modules. The map register uses a per-bit write enable decoded from count (one-hot of count & valid & ~full, or index 0 when flushing).

## Test plan
- Reset, then three valid branches T, N, T in consecutive cycles → after the third edge: map_o = 30'b010, count_o = 3, empty_o = 0, full_o = 0.
- 30 consecutive branches, all N → map_o = 30'h3FFF_FFFF, count_o = 30, full_o = 1 exactly one cycle after the 30th valid_i.
- S_FULL, then valid_i=1 and taken_i=0 without flush → map and count unchanged, overflow_o = 1 and stays 1 after a later flush.
- S_FULL with flush_i=1 and valid_i=1, taken_i=1 in the same cycle → next cycle: map_o = 0, count_o = 1, full_o = 0, overflow_o unchanged.
- Count 5, flush_i alone → next cycle: map_o = 0, count_o = 0, empty_o = 1. A further flush_i with empty map changes nothing.
- Count 12, assert rst_i asynchronously between edges → outputs return to reset values before the next edge. After release, one T branch → count_o = 1, map_o = 0.

Source files
------------

// File: rtl/trdb_pkg.sv
// trdb_pkg: shared trace-debug constants and types.
//   BRANCH_MAP_LEN   : number of bits in the branch map (format 0/1/2 payloads).
//   BRANCH_MAP_CNT_W : width needed to hold a branch count of 0..BRANCH_MAP_LEN.
//   trdb_bm_state_e  : occupancy state of the branch map accumulator.
package trdb_pkg;

  localparam int BRANCH_MAP_LEN   = 30;
  // Must hold the value BRANCH_MAP_LEN itself, hence the +1.
  localparam int BRANCH_MAP_CNT_W = $clog2(BRANCH_MAP_LEN + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACCUM = 2'd1,
    S_FULL  = 2'd2
  } trdb_bm_state_e;

endpackage

// File: rtl/trdb_branch_map_if.sv
// trdb_branch_map_if: groups the branch-map input strobes and the map outputs.
//   valid_i/taken_i : retired conditional branch and its outcome (from retire filter).
//   flush_i         : emitter captured map_o/count_o this cycle.
//   map_o/count_o   : accumulated branch map and number of valid bits.
//   empty_o/full_o  : occupancy flags; full_o is the packet request.
//   overflow_o      : sticky drop indicator.
// Handshake: full_o requests a packet; the emitter asserts flush_i in the same
// cycle it samples map_o/count_o, and full_o falls the cycle after. Upstream is
// never back-pressured; branches arriving while full are dropped and flagged.
// modport master: environment side (drives strobes). modport slave: the block.
interface trdb_branch_map_if #(
  parameter int MAP_LEN = trdb_pkg::BRANCH_MAP_LEN,
  parameter int CNT_W   = $clog2(MAP_LEN + 1)
);
  logic               valid_i;
  logic               taken_i;
  logic               flush_i;
  logic [MAP_LEN-1:0] map_o;
  logic [CNT_W-1:0]   count_o;
  logic               empty_o;
  logic               full_o;
  logic               overflow_o;

  modport master (
    output valid_i, taken_i, flush_i,
    input  map_o, count_o, empty_o, full_o, overflow_o
  );

  modport slave (
    input  valid_i, taken_i, flush_i,
    output map_o, count_o, empty_o, full_o, overflow_o
  );
endinterface

// File: rtl/trdb_branch_map.sv
// trdb_branch_map: accumulates retired conditional-branch outcomes into an
// LSB-first map (1 = not taken) with a branch count, for the packet emitter.
// Ports:
//   clk_i   : clock, all updates on rising edge.
//   rst_i   : asynchronous active-high reset.
//   bm      : trdb_branch_map_if.slave (valid_i, taken_i, flush_i in;
//             map_o, count_o, empty_o, full_o, overflow_o out).
//   state_o : current occupancy state, for observation.
// All outputs are registered; inputs in cycle N show on outputs in cycle N+1.
module trdb_branch_map
  import trdb_pkg::*;
#(
  parameter int MAP_LEN = trdb_pkg::BRANCH_MAP_LEN,
  parameter int CNT_W   = $clog2(MAP_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  trdb_branch_map_if.slave     bm,
  output trdb_bm_state_e       state_o
);

  trdb_bm_state_e     state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;

  logic               accept;
  logic               drop;
  logic [MAP_LEN-1:0] base_map;
  logic [CNT_W-1:0]   base_cnt;
  logic [MAP_LEN-1:0] wr_en;

  // Flush clears before the write, so a branch arriving with flush is always
  // accepted and lands in bit 0. Only a full map without flush drops.
  assign drop     = bm.valid_i && !bm.flush_i && (state_q == S_FULL);
  assign accept   = bm.valid_i && !drop;
  assign base_map = bm.flush_i ? '0 : map_q;
  assign base_cnt = bm.flush_i ? '0 : count_q;

  // One-hot write enable at the post-flush count.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < MAP_LEN; i++) begin
      wr_en[i] = accept && (base_cnt == CNT_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < MAP_LEN; i++) begin
      map_d[i] = wr_en[i] ? !bm.taken_i : base_map[i];
    end
  end

  assign count_d    = accept ? (base_cnt + CNT_W'(1)) : base_cnt;
  assign overflow_d = overflow_q || drop;

  // Next state follows directly from the occupancy the count will have.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (bm.valid_i) state_d = (MAP_LEN == 1) ? S_FULL : S_ACCUM;
      end
      S_ACCUM: begin
        if (bm.flush_i)
          state_d = bm.valid_i ? ((MAP_LEN == 1) ? S_FULL : S_ACCUM) : S_EMPTY;
        else if (bm.valid_i && (count_q == CNT_W'(MAP_LEN - 1)))
          state_d = S_FULL;
      end
      S_FULL: begin
        if (bm.flush_i)
          state_d = bm.valid_i ? ((MAP_LEN == 1) ? S_FULL : S_ACCUM) : S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign empty_d = (state_d == S_EMPTY);
  assign full_d  = (state_d == S_FULL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_EMPTY;
      map_q      <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      map_q      <= map_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign bm.map_o      = map_q;
  assign bm.count_o    = count_q;
  assign bm.empty_o    = empty_q;
  assign bm.full_o     = full_q;
  assign bm.overflow_o = overflow_q;
  assign state_o       = state_q;

endmodule
